// File: rtl/puf_pkg.sv
// Shared types and constants for the ring-oscillator PUF control path.
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    VOTE,
    OUTPUT
  } voter_state_t;

  localparam int PUF_CHAL_W     = 8;
  localparam int PUF_RO_CHAL_W  = 6;
  localparam int PUF_RESP_W     = 8;
  localparam int PUF_PARITY_BIT = 7;

endpackage

// File: rtl/puf_bit_voter.sv
// Per-bit ones counter for repeated PUF evaluations; yields the majority bit and,
// when PUF_UNSTABLE_MASK_EN is defined, a unanimity flag.
module puf_bit_voter #(
  parameter int NUM_EVAL = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
`ifdef PUF_UNSTABLE_MASK_EN
  output logic unanimous,
`endif
  output logic majority
);

  localparam int CNT_W = $clog2(NUM_EVAL + 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(NUM_EVAL / 2);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_EVAL);

  logic [CNT_W-1:0] ones;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ones <= '0;
    end else if (inc) begin
      ones <= ones + 1'b1;
    end
  end

  assign majority = ones > HALF;

`ifdef PUF_UNSTABLE_MASK_EN
  assign unanimous = (ones == '0) || (ones == FULL);
`endif

endmodule

// File: rtl/puf_response_voter.sv
// Drives NUM_EVAL parity-toggled PUF evaluations per challenge and majority-votes the responses
// into a key byte. Optional UNSTABLE output when PUF_UNSTABLE_MASK_EN is defined.
module puf_response_voter
  import puf_pkg::*;
#(
  parameter int NUM_EVAL    = 5,
  parameter int RESP_W      = PUF_RESP_W,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [PUF_RO_CHAL_W-1:0] req_challenge,
  output logic [PUF_CHAL_W-1:0]    puf_challenge,
  input  logic [RESP_W-1:0]        puf_response,
  input  logic                     puf_done,
  output logic                     key_valid,
  input  logic                     key_ready,
  output logic [RESP_W-1:0]        key,
`ifdef PUF_UNSTABLE_MASK_EN
  output logic [RESP_W-1:0]        unstable,
`endif
  output logic                     key_err
);

  localparam int EVAL_W = $clog2(NUM_EVAL + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYC);
  localparam logic [EVAL_W-1:0] EVAL_LAST = EVAL_W'(NUM_EVAL - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

  voter_state_t state, state_next;

  logic [PUF_RO_CHAL_W-1:0] chal;
  logic                     parity;
  logic [EVAL_W-1:0]        eval_cnt;
  logic [TMO_W-1:0]         tmo_cnt;
  logic                     accept;
  logic                     waiting;
  logic                     timeout;
  logic                     sample;
  logic [RESP_W-1:0]        majority_vec;
  logic                     resp_bit0_unused;

  assign accept  = req_valid && req_ready;
  assign waiting = (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign timeout = waiting && (tmo_cnt == TMO_LAST);
  assign sample  = (state == WAIT_DONE) && puf_done && !timeout;

  // Bit 0 of the response has no RO pair behind it, so it never votes.
  assign resp_bit0_unused = puf_response[0];
  assign majority_vec[0]  = 1'b0;

`ifdef PUF_UNSTABLE_MASK_EN
  logic [RESP_W-1:0] unanimous_vec;
  assign unanimous_vec[0] = 1'b1;
`endif

  for (genvar i = 1; i < RESP_W; i++) begin : g_bit
    puf_bit_voter #(.NUM_EVAL(NUM_EVAL)) u_voter (
      .clk       (clk),
      .reset     (reset),
      .clear     (accept),
      .inc       (sample && puf_response[i]),
`ifdef PUF_UNSTABLE_MASK_EN
      .unanimous (unanimous_vec[i]),
`endif
      .majority  (majority_vec[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    key_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = ISSUE;
      end
      ISSUE: state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (timeout)        state_next = OUTPUT;
        else if (!puf_done) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (timeout)       state_next = OUTPUT;
        else if (puf_done) state_next = (eval_cnt == EVAL_LAST) ? VOTE : ISSUE;
      end
      VOTE: state_next = OUTPUT;
      OUTPUT: begin
        key_valid = 1'b1;
        if (key_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chal     <= '0;
      parity   <= 1'b0;
      eval_cnt <= '0;
      tmo_cnt  <= '0;
      key      <= '0;
      key_err  <= 1'b0;
`ifdef PUF_UNSTABLE_MASK_EN
      unstable <= '0;
`endif
    end else begin
      if (accept) begin
        chal     <= req_challenge;
        eval_cnt <= '0;
      end
      // A parity change on the unrouted challenge bit is what starts each evaluation.
      if (state == ISSUE) begin
        parity  <= ~parity;
        tmo_cnt <= '0;
      end else if (waiting) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (sample) eval_cnt <= eval_cnt + 1'b1;
      if (timeout) begin
        key     <= '0;
        key_err <= 1'b1;
`ifdef PUF_UNSTABLE_MASK_EN
        unstable <= '0;
`endif
      end else if (state == VOTE) begin
        key     <= majority_vec;
        key_err <= 1'b0;
`ifdef PUF_UNSTABLE_MASK_EN
        unstable <= ~unanimous_vec;
`endif
      end
    end
  end

  always_comb begin
    puf_challenge                      = '0;
    puf_challenge[PUF_RO_CHAL_W-1:0]   = chal;
    puf_challenge[PUF_PARITY_BIT]      = parity;
  end

endmodule

// File: tb/tb_puf_response_voter.sv
// Directed bench for puf_response_voter with a behavioural PUF model (programmable start delay,
// evaluation time and per-evaluation response list).
module tb_puf_response_voter;

  localparam int NUM_EVAL    = 5;
  localparam int RESP_W      = 8;
  localparam int TIMEOUT_CYC = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [5:0]        req_challenge;
  logic [7:0]        puf_challenge;
  logic [RESP_W-1:0] puf_response;
  logic              puf_done;
  logic              key_valid;
  logic              key_ready;
  logic [RESP_W-1:0] key;
  logic              key_err;
`ifdef PUF_UNSTABLE_MASK_EN
  logic [RESP_W-1:0] unstable;
`endif

  puf_response_voter #(
    .NUM_EVAL    (NUM_EVAL),
    .RESP_W      (RESP_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_challenge (req_challenge),
    .puf_challenge (puf_challenge),
    .puf_response  (puf_response),
    .puf_done      (puf_done),
    .key_valid     (key_valid),
    .key_ready     (key_ready),
    .key           (key),
`ifdef PUF_UNSTABLE_MASK_EN
    .unstable      (unstable),
`endif
    .key_err       (key_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Behavioural PUF: DONE drops start_dly cycles after a parity change, rises eval_time later.
  logic [RESP_W-1:0] resp_list [5];
  int   resp_idx    = 0;
  int   eval_time   = 3;
  int   start_dly   = 1;
  bit   hang        = 1'b0;
  logic last_par    = 1'b0;
  int   par_toggles = 0;
  bit   m_busy      = 1'b0;
  int   m_start     = 0;
  int   m_cnt       = 0;

  initial begin
    puf_done     = 1'b1;
    puf_response = 8'hFF;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        m_busy   = 1'b0;
        m_start  = 0;
        m_cnt    = 0;
        puf_done = 1'b1;
        last_par = 1'b0;
      end else if (!m_busy) begin
        if (puf_challenge[7] !== last_par) begin
          last_par = puf_challenge[7];
          par_toggles++;
          if (!hang) begin
            m_busy  = 1'b1;
            m_start = start_dly;
          end
        end
      end else if (m_start > 0) begin
        m_start--;
        if (m_start == 0) begin
          puf_done = 1'b0;
          m_cnt    = eval_time;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          puf_response = resp_list[resp_idx % 5];
          resp_idx++;
          puf_done = 1'b1;
          m_busy   = 1'b0;
        end
      end
    end
  end

  bit mon_chal = 1'b0;
  int chal_bad = 0;
  initial forever begin
    @(negedge clk);
    if (mon_chal && puf_challenge[6:0] !== 7'h2A) chal_bad++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic load_resp(input logic [7:0] r0, r1, r2, r3, r4);
    resp_list[0] = r0; resp_list[1] = r1; resp_list[2] = r2;
    resp_list[3] = r3; resp_list[4] = r4;
    resp_idx = 0;
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic start_req(input logic [5:0] c);
    int n = 0;
    req_valid     = 1'b1;
    req_challenge = c;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_seen", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Latency counts posedges from the accept edge (inclusive) to the one raising KEY_VALID.
  task automatic wait_key(output int cyc);
    cyc = 1;
    while (!key_valid && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("key_valid_seen", key_valid, 1'b1);
  endtask

  task automatic take_key();
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  int lat;
  int n;
  int stall_bad;
  int tog_snap;

  initial begin
    reset         = 1'b1;
    req_valid     = 1'b0;
    req_challenge = '0;
    key_ready     = 1'b0;
    load_resp(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key", key, 8'h00);
    check("rst_key_err", key_err, 1'b0);
    check("rst_puf_chal", puf_challenge, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    // 1: stable responses; 5 parity toggles; latency 1 + 5*(2+3+1) + 1 = 32
    load_resp(8'hB6, 8'hB6, 8'hB6, 8'hB6, 8'hB6);
    par_toggles = 0;
    chal_bad    = 0;
    start_req(6'h2A);
    mon_chal = 1'b1;
    wait_key(lat);
    mon_chal = 1'b0;
    check("t1_key", key, 8'hB6);
    check("t1_err", key_err, 1'b0);
    check("t1_toggles", par_toggles, 5);
    check("t1_chal_held", chal_bad, 0);
    check("t1_latency", lat, 32);
`ifdef PUF_UNSTABLE_MASK_EN
    check("t1_unstable", unstable, 8'h00);
`endif
    take_key();

    // 2: bit 1 unanimous, bits 7..2 three of five
    load_resp(8'hFE, 8'hFE, 8'h02, 8'hFE, 8'h02);
    start_req(6'h11);
    wait_key(lat);
    check("t2_key", key, 8'hFE);
    check("t2_err", key_err, 1'b0);
`ifdef PUF_UNSTABLE_MASK_EN
    check("t2_unstable", unstable, 8'hFC);
`endif
    take_key();

    // 3: PUF never drops DONE; accept + ISSUE + 64 waiting cycles = 66
    hang = 1'b1;
    start_req(6'h05);
    wait_key(lat);
    check("t3_latency", lat, 66);
    check("t3_key", key, 8'h00);
    check("t3_err", key_err, 1'b1);
`ifdef PUF_UNSTABLE_MASK_EN
    check("t3_unstable", unstable, 8'h00);
`endif
    take_key();
    hang = 1'b0;

    // 4: consumer stalls 20 cycles while a new request waits
    load_resp(8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C);
    start_req(6'h07);
    wait_key(lat);
    check("t4_key", key, 8'h3C);
    tog_snap      = par_toggles;
    stall_bad     = 0;
    req_valid     = 1'b1;
    req_challenge = 6'h09;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (key !== 8'h3C || key_valid !== 1'b1 || req_ready !== 1'b0) stall_bad++;
    end
    check("t4_stall_stable", stall_bad, 0);
    check("t4_no_new_eval", par_toggles, tog_snap);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    check("t4_idle_valid", key_valid, 1'b0);
    check("t4_idle_ready", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    check("t4_accepted", req_ready, 1'b0);
    check("t4_new_chal", puf_challenge[5:0], 6'h09);
    wait_key(lat);
    check("t4b_key", key, 8'h3C);
    take_key();

    // 5: reset during the third evaluation, then a fresh request
    load_resp(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    start_req(6'h3F);
    n = 0;
    while (resp_idx < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (puf_done !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t5_in_third_eval", puf_done, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_ready", req_ready, 1'b1);
    check("t5_rst_valid", key_valid, 1'b0);
    check("t5_rst_chal", puf_challenge, 8'h00);
    reset = 1'b0;
    load_resp(8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A);
    @(negedge clk);
    start_req(6'h15);
    check("t5_chal", puf_challenge[5:0], 6'h15);
    wait_key(lat);
    check("t5_key", key, 8'h5A);
    check("t5_err", key_err, 1'b0);
    take_key();

    // 6: bit 0 always set, DONE stays high 2 cycles into WAIT_BUSY
    start_dly    = 2;
    puf_response = 8'hFF;
    load_resp(8'h81, 8'h81, 8'h81, 8'h7F, 8'h7F);
    par_toggles = 0;
    start_req(6'h2B);
    wait_key(lat);
    check("t6_key", key, 8'h80);
    check("t6_err", key_err, 1'b0);
    check("t6_evals", resp_idx, 5);
    check("t6_toggles", par_toggles, 5);
`ifdef PUF_UNSTABLE_MASK_EN
    check("t6_unstable", unstable, 8'hFE);
`endif
    take_key();

    // KEY_READY held high in IDLE has no effect
    key_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ready_hold", req_ready, 1'b1);
    check("idle_valid_hold", key_valid, 1'b0);
    key_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
